// File: rtl/wb_broadcast_arbiter.sv
// -----------------------------------------------------------------------------
// wb_broadcast_arbiter
//
// Writeback-side producer for the busy table and the issue-queue wakeup.
// Each functional unit (FU) pushes its destination physical register into a
// small private completion FIFO. Every cycle up to four FIFO heads are picked
// round-robin and broadcast on four lanes. The lanes are registered and packed
// from lane 0. A recover flush drops every pending completion.
//
// Configuration macro:
//   WB_ARB_BYPASS_EN  When defined, an FU whose FIFO is empty and that hands in
//                     a completion can win a lane in the same cycle. The entry
//                     then skips its FIFO, which gives 1-cycle latency. When
//                     undefined, only FIFO heads compete, which gives 2-cycle
//                     latency.
//
// Ports:
//   clk              clock
//   rst_n            asynchronous active-low reset
//   fu_wb_valid      [FU_NUM]         FU i presents a completion
//   fu_wb_rd_index   [FU_NUM*PREG_W]  FU i dest preg at [i*PREG_W +: PREG_W]
//   fu_wb_ready      [FU_NUM]         FU i completion accepted on valid&ready
//   recover_valid    flush: clear FIFOs, block enqueue, suppress grants
//   wb_rd_index_0..3 [PREG_W]         broadcast lane preg indices
//   wb_rd_exist_vec  [4]              lane k carries a valid completion
// -----------------------------------------------------------------------------
`ifndef PREG_INDEX_WIDTH
`define PREG_INDEX_WIDTH 7
`endif

module wb_broadcast_arbiter #(
  parameter int FU_NUM     = 6,
  parameter int FIFO_DEPTH = 2,
  parameter int PREG_W     = `PREG_INDEX_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FU_NUM-1:0]        fu_wb_valid,
  input  logic [FU_NUM*PREG_W-1:0] fu_wb_rd_index,
  output logic [FU_NUM-1:0]        fu_wb_ready,
  input  logic                     recover_valid,
  output logic [PREG_W-1:0]        wb_rd_index_0,
  output logic [PREG_W-1:0]        wb_rd_index_1,
  output logic [PREG_W-1:0]        wb_rd_index_2,
  output logic [PREG_W-1:0]        wb_rd_index_3,
  output logic [3:0]               wb_rd_exist_vec
);

  localparam int LANES = 4;
  localparam int FU_W  = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int GNT_W = $clog2(LANES + 1);

  // Wraps base+off into [0, FU_NUM). FU_NUM need not be a power of two.
  function automatic logic [FU_W-1:0] wrap_add(input logic [FU_W-1:0] base,
                                               input int unsigned    off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= unsigned'(FU_NUM)) sum = sum - unsigned'(FU_NUM);
    return FU_W'(sum);
  endfunction

  // Per-FU completion FIFOs
  logic [PREG_W-1:0] r_mem    [FU_NUM][FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr [FU_NUM];
  logic [PTR_W-1:0]  r_rd_ptr [FU_NUM];
  logic [CNT_W-1:0]  r_count  [FU_NUM];

  // Arbitration state and registered broadcast bus
  logic [FU_W-1:0]   r_rr_ptr;
  logic [PREG_W-1:0] r_wb_idx [LANES];
  logic [LANES-1:0]  r_wb_exist;

  logic [FU_NUM-1:0] w_ready;
  logic [FU_NUM-1:0] w_eligible;
  logic [FU_NUM-1:0] w_pop;
  logic [FU_NUM-1:0] w_bypass;
  logic [FU_NUM-1:0] w_push;
  logic [PREG_W-1:0] w_lane_idx [LANES];
  logic [LANES-1:0]  w_lane_vld;
  logic [GNT_W-1:0]  w_n_grant;
  logic [FU_W-1:0]   w_fu;
  logic [FU_W-1:0]   w_rr_next;

  // Ready looks only at the registered count. A full FIFO that is popped this
  // cycle still reports not-ready, so there is no comb path from arbitration.
  always_comb begin
    for (int i = 0; i < FU_NUM; i++) begin
      w_ready[i] = (r_count[i] < CNT_W'(FIFO_DEPTH)) && !recover_valid;
    end
  end

  always_comb begin
    for (int i = 0; i < FU_NUM; i++) begin
`ifdef WB_ARB_BYPASS_EN
      w_eligible[i] = (r_count[i] != '0) || (fu_wb_valid[i] && w_ready[i]);
`else
      w_eligible[i] = (r_count[i] != '0);
`endif
    end
  end

  // Round-robin scan starting at r_rr_ptr. The first four eligible FUs fill
  // lanes 0..3 in scan order.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_pop      = '0;
    w_bypass   = '0;
    w_lane_vld = '0;
    w_n_grant  = '0;
    w_fu       = '0;
    w_rr_next  = r_rr_ptr;
    for (int l = 0; l < LANES; l++) w_lane_idx[l] = '0;

    for (int k = 0; k < FU_NUM; k++) begin
      w_fu = wrap_add(r_rr_ptr, k);
      if (!recover_valid && w_eligible[w_fu] && (w_n_grant < GNT_W'(LANES))) begin
        w_lane_vld[w_n_grant[1:0]] = 1'b1;
        if (r_count[w_fu] != '0) begin
          w_lane_idx[w_n_grant[1:0]] = r_mem[w_fu][r_rd_ptr[w_fu]];
          w_pop[w_fu]                = 1'b1;
        end else begin
          // Reachable only when bypass makes an empty FIFO eligible.
          w_lane_idx[w_n_grant[1:0]] = fu_wb_rd_index[w_fu*PREG_W +: PREG_W];
          w_bypass[w_fu]             = 1'b1;
        end
        w_rr_next = wrap_add(w_fu, 1);
        w_n_grant = w_n_grant + 1'b1;
      end
    end
  end

  // A bypassed completion is consumed by its lane and never enters the FIFO.
  assign w_push = fu_wb_valid & w_ready & ~w_bypass;

  // NOTE: FIFO storage has no reset; count and pointers say which slots are live, so stale contents are never read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FU_NUM; i++) begin
      if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= fu_wb_rd_index[i*PREG_W +: PREG_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FU_NUM; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      for (int l = 0; l < LANES; l++) r_wb_idx[l] <= '0;
      r_wb_exist <= '0;
      r_rr_ptr   <= '0;
    end else if (recover_valid) begin
      for (int i = 0; i < FU_NUM; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      for (int l = 0; l < LANES; l++) r_wb_idx[l] <= '0;
      r_wb_exist <= '0;
      r_rr_ptr   <= '0;
    end else begin
      for (int i = 0; i < FU_NUM; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
        r_count[i] <= r_count[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
      end
      // Unused lanes are already zeroed in w_lane_idx.
      for (int l = 0; l < LANES; l++) r_wb_idx[l] <= w_lane_idx[l];
      r_wb_exist <= w_lane_vld;
      r_rr_ptr   <= w_rr_next;
    end
  end

  assign fu_wb_ready     = w_ready;
  assign wb_rd_index_0   = r_wb_idx[0];
  assign wb_rd_index_1   = r_wb_idx[1];
  assign wb_rd_index_2   = r_wb_idx[2];
  assign wb_rd_index_3   = r_wb_idx[3];
  assign wb_rd_exist_vec = r_wb_exist;

endmodule
